hazard_forward_unit: RTL

//  Pipeline hazard controller for the 5-stage CPU. It keeps a shadow copy of dest-reg/write/load info for EX, MEM and WB.
//  It drives the PC/IF_ID load enable (LE), the CU_MUX bubble select (S) and the IF_ID squash (FLUSH).
//  It also produces operand forwarding selects for the ID-stage register-file read ports.
//  It sits beside the decode stage, between CONTROL_UNIT outputs and the ID_EX register.

---
 rtl/hazard_forward_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks dest/write/load info
// for EX, MEM and WB, and generates stall, bubble, squash and operand-forward selects.
module hazard_forward_unit #(
  parameter int REG_AW      = 5,
  parameter int LOAD_STALLS = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [REG_AW-1:0] ID_RA,
  input  logic [REG_AW-1:0] ID_RB,
  input  logic              ID_RA_USE,
  input  logic              ID_RB_USE,
  input  logic [REG_AW-1:0] ID_RD,
  input  logic              ID_RF_LE,
  input  logic              ID_L,
  input  logic              BR_TAKEN,
  output logic              LE,
  output logic              S,
  output logic              FLUSH,
  output logic [1:0]        FWD_A,
  output logic [1:0]        FWD_B,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;

  // Shadow of the instructions now in EX, MEM and WB; only EX needs its load bit.
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              ex_wr, mem_wr, wb_wr;
  logic              ex_ld;
  logic              lu;

  function automatic logic hit(input logic rd_en, input logic [REG_AW-1:0] r,
                               input logic [REG_AW-1:0] st_rd, input logic st_wr);
    return rd_en && (r != '0) && st_wr && (st_rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic rd_en, input logic [REG_AW-1:0] r);
    if (hit(rd_en, r, ex_rd, ex_wr))        return 2'b01;
    else if (hit(rd_en, r, mem_rd, mem_wr)) return 2'b10;
    else if (hit(rd_en, r, wb_rd, wb_wr))   return 2'b11;
    else                                    return 2'b00;
  endfunction

  assign lu = ex_ld && (hit(ID_RA_USE, ID_RA, ex_rd, ex_wr) ||
                        hit(ID_RB_USE, ID_RB, ex_rd, ex_wr));

  assign FWD_A     = fwd_sel(ID_RA_USE, ID_RA);
  assign FWD_B     = fwd_sel(ID_RB_USE, ID_RB);
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    LE      = 1'b1;
    S       = 1'b0;
    FLUSH   = 1'b0;
    case (state)
      ST_RUN: begin
        if (BR_TAKEN) begin
          FLUSH   = 1'b1;
          S       = 1'b1;
          state_n = ST_FLUSH;
        end else if (lu) begin
          LE    = 1'b0;
          S     = 1'b1;
          cnt_n = 2'(LOAD_STALLS - 1);
          if (LOAD_STALLS > 1) state_n = ST_STALL;
        end
      end
      ST_STALL: begin
        // A taken branch squashes the stalled instruction, so the stall is moot.
        if (BR_TAKEN) begin
          FLUSH   = 1'b1;
          S       = 1'b1;
          cnt_n   = '0;
          state_n = ST_FLUSH;
        end else begin
          LE    = 1'b0;
          S     = 1'b1;
          cnt_n = cnt - 2'd1;
          if (cnt_n == '0) state_n = ST_RUN;
        end
      end
      ST_FLUSH: begin
        S       = 1'b1;
        state_n = ST_RUN;
      end
      default: state_n = ST_RUN;
    endcase
    if (Rst) begin
      LE    = 1'b1;
      S     = 1'b0;
      FLUSH = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= ST_RUN;
      cnt    <= '0;
      ex_rd  <= '0;
      mem_rd <= '0;
      wb_rd  <= '0;
      ex_wr  <= 1'b0;
      mem_wr <= 1'b0;
      wb_wr  <= 1'b0;
      ex_ld  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      wb_rd  <= mem_rd;
      wb_wr  <= mem_wr;
      mem_rd <= ex_rd;
      mem_wr <= ex_wr;
      ex_rd  <= ID_RD;
      ex_wr  <= ID_RF_LE & ~S;
      ex_ld  <= ID_L & ~S;
    end
  end

endmodule
